// File: rtl/logic_capture_pkg.sv
// Shared types and helpers for the logic capture core.
package logic_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT_TRIG,
    POST,
    DONE
  } capState_t;

  function automatic int addrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/logic_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module logic_capture_ram
  import logic_capture_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  localparam int AW    = addrWidth(DEPTH)
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              wrEn,
  input  logic [AW-1:0]     wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  input  logic [AW-1:0]     rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)     rdData <= '0;
    else if (rdEn) rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/logic_capture_core.sv
// Logic analyser capture core: circular sample buffer with masked trigger and pre-trigger window.
// Optional macro LOGIC_CAPTURE_TRIG_EDGE_EN selects a rising-edge trigger instead of a level trigger.
//   state     | meaning
//   IDLE      | waiting for arm
//   FILL      | collecting the pre-trigger window, matches ignored
//   WAIT_TRIG | overwriting the ring until the trigger fires
//   POST      | collecting post-trigger samples
//   DONE      | capture frozen, readable
module logic_capture_core
  import logic_capture_pkg::*;
#(
  parameter int PROBE_W  = 64,
  parameter int TRIG_W   = 22,
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 256,
  localparam int AW      = addrWidth(DEPTH)
) (
  input  logic               crystalClk,
  input  logic               resetN,
  input  logic               arm,
  input  logic               abort,
  input  logic [PROBE_W-1:0] probeIn,
  input  logic [TRIG_W-1:0]  trigIn,
  input  logic [TRIG_W-1:0]  trigValue,
  input  logic [TRIG_W-1:0]  trigMask,
  output logic               busy,
  output logic               triggered,
  output logic               done,
  input  logic               rdEn,
  input  logic [AW-1:0]      rdAddr,
  output logic [PROBE_W-1:0] rdData,
  output logic               rdValid
);

  localparam int            POST_N    = DEPTH - PRE_TRIG - 1;
  localparam logic [AW-1:0] PRE_LAST  = (PRE_TRIG > 0) ? AW'(PRE_TRIG - 1) : '0;
  localparam logic [AW-1:0] POST_LAST = (POST_N > 0) ? AW'(POST_N - 1) : '0;
  localparam logic [AW-1:0] PRE_OFF   = AW'(PRE_TRIG);

  capState_t     state, stateNext;
  logic [AW-1:0] wrPtr, cnt, startPtr;
  logic          armOk, match, fire, ramRdEn;

  assign armOk = arm && (state == IDLE || state == DONE);
  assign match = ((trigIn ^ trigValue) & trigMask) == '0;

`ifdef LOGIC_CAPTURE_TRIG_EDGE_EN
  // histValid keeps a match that is already present at arm from counting as an edge
  logic matchPrev, histValid;

  always_ff @(posedge crystalClk or negedge resetN) begin
    if (!resetN) begin
      matchPrev <= 1'b0;
      histValid <= 1'b0;
    end else if (armOk || abort) begin
      matchPrev <= 1'b0;
      histValid <= 1'b0;
    end else if (busy) begin
      matchPrev <= match;
      histValid <= 1'b1;
    end
  end

  assign fire = match && histValid && !matchPrev;
`else
  assign fire = match;
`endif

  always_ff @(posedge crystalClk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (abort) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (arm) stateNext = (PRE_TRIG == 0) ? WAIT_TRIG : FILL;
        FILL:       if (cnt == '0) stateNext = WAIT_TRIG;
        WAIT_TRIG:  if (fire) stateNext = (POST_N == 0) ? DONE : POST;
        POST:       if (cnt == '0) stateNext = DONE;
        default:    stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      FILL, WAIT_TRIG, POST: busy = 1'b1;
      DONE:                  done = 1'b1;
      default: ;
    endcase
  end

  // cnt is a down-counter reused for the pre-trigger and post-trigger windows
  always_ff @(posedge crystalClk or negedge resetN) begin
    if (!resetN) begin
      wrPtr     <= '0;
      cnt       <= '0;
      startPtr  <= '0;
      triggered <= 1'b0;
    end else if (abort) begin
      wrPtr     <= '0;
      cnt       <= '0;
      triggered <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            wrPtr     <= '0;
            cnt       <= PRE_LAST;
            triggered <= 1'b0;
          end
        end
        FILL, POST: begin
          wrPtr <= wrPtr + 1'b1;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        WAIT_TRIG: begin
          wrPtr <= wrPtr + 1'b1;
          if (fire) begin
            triggered <= 1'b1;
            startPtr  <= wrPtr - PRE_OFF;
            cnt       <= POST_LAST;
          end
        end
        default: ;
      endcase
    end
  end

  assign ramRdEn = rdEn && (state == DONE);

  always_ff @(posedge crystalClk or negedge resetN) begin
    if (!resetN) rdValid <= 1'b0;
    else         rdValid <= ramRdEn;
  end

  logic_capture_ram #(
    .DATA_W (PROBE_W),
    .DEPTH  (DEPTH)
  ) uRam (
    .clk    (crystalClk),
    .rstN   (resetN),
    .wrEn   (busy),
    .wrAddr (wrPtr),
    .wrData (probeIn),
    .rdEn   (ramRdEn),
    .rdAddr (startPtr + rdAddr),
    .rdData (rdData)
  );

endmodule

// File: tb/tb_logic_capture_core.sv
// Directed bench for logic_capture_core: DEPTH=16 with PRE_TRIG=4 and PRE_TRIG=0 instances.
module tb_logic_capture_core;
  localparam int PW = 64;
  localparam int TW = 22;
  localparam int D  = 16;

  logic          crystalClk = 1'b0;
  logic          resetN = 1'b0;
  logic          arm = 1'b0, abort = 1'b0, rdEn = 1'b0;
  logic [3:0]    rdAddr = '0;
  logic [TW-1:0] trigValue = '0, trigMask = '0, trigManual = '0;
  logic          trigSel = 1'b0;
  logic [31:0]   cnt;
  logic [PW-1:0] probeIn;
  logic [TW-1:0] trigIn;

  logic          busy, triggered, done, rdValid;
  logic [PW-1:0] rdData;
  logic          busy0, triggered0, done0, rdValid0;
  logic [PW-1:0] rdData0;

  int nCmp = 0;
  int nErr = 0;

  assign probeIn = {32'h0, cnt};
  assign trigIn  = trigSel ? trigManual : cnt[TW-1:0];

  always #5 crystalClk = ~crystalClk;

  always @(posedge crystalClk or negedge resetN) begin
    if (!resetN) cnt <= '0;
    else         cnt <= cnt + 1;
  end

  logic_capture_core #(.PROBE_W(PW), .TRIG_W(TW), .DEPTH(D), .PRE_TRIG(4)) dut (
    .crystalClk(crystalClk), .resetN(resetN), .arm(arm), .abort(abort),
    .probeIn(probeIn), .trigIn(trigIn), .trigValue(trigValue), .trigMask(trigMask),
    .busy(busy), .triggered(triggered), .done(done),
    .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData), .rdValid(rdValid)
  );

  logic_capture_core #(.PROBE_W(PW), .TRIG_W(TW), .DEPTH(D), .PRE_TRIG(0)) dut0 (
    .crystalClk(crystalClk), .resetN(resetN), .arm(arm), .abort(abort),
    .probeIn(probeIn), .trigIn(trigIn), .trigValue(trigValue), .trigMask(trigMask),
    .busy(busy0), .triggered(triggered0), .done(done0),
    .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData0), .rdValid(rdValid0)
  );

  task automatic doReset();
    resetN = 1'b0; arm = 1'b0; abort = 1'b0; rdEn = 1'b0; trigSel = 1'b0; trigManual = '0;
    repeat (2) @(negedge crystalClk);
    resetN = 1'b1;
  endtask

  task automatic waitCnt(input int v);
    int k = 0;
    while (cnt != 32'(v) && k < 1000) begin @(negedge crystalClk); k++; end
    nCmp++;
    if (cnt != 32'(v)) begin nErr++; $display("FAIL waitCnt: count %0d, want %0d", cnt, v); end
  endtask

  task automatic armAt(input int v);
    waitCnt(v);
    arm = 1'b1;
    @(negedge crystalClk);
    arm = 1'b0;
  endtask

  task automatic waitDone(input bit sel, input int expCnt);
    int k = 0;
    while (!(sel ? done0 : done) && k < 500) begin @(negedge crystalClk); k++; end
    nCmp++;
    if (!(sel ? done0 : done) || (expCnt >= 0 && cnt != 32'(expCnt))) begin
      nErr++;
      $display("FAIL waitDone: done %b at count %0d, want 1 at count %0d", sel ? done0 : done, cnt, expCnt);
    end
  endtask

  task automatic readCheck(input bit sel, input int base, input string name);
    logic [PW-1:0] got;
    logic          vld;
    for (int i = 0; i < D; i++) begin
      rdEn = 1'b1; rdAddr = 4'(i);
      @(negedge crystalClk);
      got = sel ? rdData0 : rdData;
      vld = sel ? rdValid0 : rdValid;
      nCmp++;
      if (vld !== 1'b1 || got !== PW'(base + i)) begin
        nErr++;
        $display("FAIL %s idx %0d: got %0d valid %b, want %0d valid 1", name, i, got, vld, base + i);
      end
    end
    rdEn = 1'b0;
    @(negedge crystalClk);
    nCmp++;
    if ((sel ? rdValid0 : rdValid) !== 1'b0) begin
      nErr++; $display("FAIL %s rdValid after reads: got 1, want 0", name);
    end
  endtask

  task automatic test_reset();
    doReset();
    nCmp++; if (busy !== 1'b0)      begin nErr++; $display("FAIL reset busy: got %b want 0", busy); end
    nCmp++; if (triggered !== 1'b0) begin nErr++; $display("FAIL reset triggered: got %b want 0", triggered); end
    nCmp++; if (done !== 1'b0)      begin nErr++; $display("FAIL reset done: got %b want 0", done); end
    nCmp++; if (rdValid !== 1'b0)   begin nErr++; $display("FAIL reset rdValid: got %b want 0", rdValid); end
    nCmp++; if (rdData !== '0)      begin nErr++; $display("FAIL reset rdData: got %0h want 0", rdData); end
  endtask

  task automatic test_basic();
    doReset();
    trigMask = 22'h3FFFFF; trigValue = 22'd40;
    armAt(10);
    nCmp++; if (busy !== 1'b1) begin nErr++; $display("FAIL basic busy after arm: got %b want 1", busy); end
    waitDone(1'b0, 52);
    nCmp++; if (triggered !== 1'b1) begin nErr++; $display("FAIL basic triggered: got %b want 1", triggered); end
    readCheck(1'b0, 36, "basic");
  endtask

  task automatic test_immediate();
    doReset();
    trigMask = '0; trigValue = 22'd40;
    armAt(10);
    waitDone(1'b0, -1);
    readCheck(1'b0, 11, "immediate");
  endtask

  task automatic test_pre0();
    doReset();
    trigMask = 22'h3FFFFF; trigValue = 22'd100;
    armAt(5);
    waitDone(1'b1, 116);
    readCheck(1'b1, 100, "pre0");
  endtask

  task automatic test_wrap();
    doReset();
    trigMask = 22'h3FFFFF; trigValue = 22'd70;
    armAt(0);
    waitDone(1'b0, 82);
    readCheck(1'b0, 66, "wrap");
  endtask

  task automatic test_abort();
    int k = 0;
    doReset();
    trigMask = 22'h3FFFFF; trigValue = 22'd40;
    armAt(10);
    while (!triggered && k < 200) begin @(negedge crystalClk); k++; end
    nCmp++; if (triggered !== 1'b1 || busy !== 1'b1) begin
      nErr++; $display("FAIL abort reach POST: triggered %b busy %b, want 1 1", triggered, busy);
    end
    abort = 1'b1;
    @(negedge crystalClk);
    abort = 1'b0;
    nCmp++; if ({busy, triggered, done} !== 3'b000) begin
      nErr++; $display("FAIL abort flags: got %b want 000", {busy, triggered, done});
    end
    rdEn = 1'b1; rdAddr = 4'd3;
    @(negedge crystalClk);
    rdEn = 1'b0;
    nCmp++; if (rdValid !== 1'b0 || rdData !== '0) begin
      nErr++; $display("FAIL abort read: valid %b data %0h, want 0 0", rdValid, rdData);
    end
    trigMask = '0;
    arm = 1'b1; @(negedge crystalClk); arm = 1'b0;
    waitDone(1'b0, -1);
    arm = 1'b1; abort = 1'b1;
    @(negedge crystalClk);
    arm = 1'b0; abort = 1'b0;
    nCmp++; if ({busy, triggered, done} !== 3'b000) begin
      nErr++; $display("FAIL abort+arm flags: got %b want 000", {busy, triggered, done});
    end
    rdEn = 1'b1; rdAddr = 4'd0;
    @(negedge crystalClk);
    rdEn = 1'b0;
    nCmp++; if (rdValid !== 1'b0) begin nErr++; $display("FAIL abort+arm read: valid %b want 0", rdValid); end
  endtask

  task automatic test_edge();
    doReset();
    trigSel = 1'b1; trigMask = 22'h3FFFFF; trigValue = 22'd5;
    waitCnt(20);
    trigManual = 22'd5;
    armAt(20);
    waitCnt(28);
    nCmp++; if (triggered !== 1'b0) begin nErr++; $display("FAIL edge held level: triggered %b want 0", triggered); end
    trigManual = '0;
    @(negedge crystalClk);
    trigManual = 22'd5;
    waitDone(1'b0, 41);
    readCheck(1'b0, 25, "edge");
  endtask

  initial begin
    test_reset();
    test_basic();
`ifndef LOGIC_CAPTURE_TRIG_EDGE_EN
    test_immediate();
`endif
    test_pre0();
    test_wrap();
    test_abort();
`ifdef LOGIC_CAPTURE_TRIG_EDGE_EN
    test_edge();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
